rom_read_arbiter: RTL and testbench

ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

---
 rtl/rom_read_arbiter_if.sv | 26 ++
 rtl/rom_read_arbiter.sv | 161 ++++++++++++++++
 tb/tb_rom_read_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_read_arbiter_if.sv
// Requester-side bundle of the ROM read arbiter: burst requests in, one-hot responses out.
// The master modport is the requester side and the slave modport is the arbiter side.
interface rom_read_arbiter_if #(
    parameter int c_NUM_REQ    = 4,
    parameter int c_ADDR_WIDTH = 10,
    parameter int c_DATA_WIDTH = 32,
    parameter int c_LEN_WIDTH  = 4
);
    logic [c_NUM_REQ-1:0]              req_valid;
    logic [c_NUM_REQ*c_ADDR_WIDTH-1:0] req_addr;
    logic [c_NUM_REQ*c_LEN_WIDTH-1:0]  req_len;
    logic [c_NUM_REQ-1:0]              req_ready;
    logic [c_NUM_REQ-1:0]              rsp_valid;
    logic                              rsp_last;
    logic [c_DATA_WIDTH-1:0]           rsp_data;

    modport master (
        output req_valid, req_addr, req_len,
        input  req_ready, rsp_valid, rsp_last, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_len,
        output req_ready, rsp_valid, rsp_last, rsp_data
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter that shares one ROM read port among several burst requesters.
// Issued addresses travel through a latency-matched pipeline that steers returning data.
module rom_read_arbiter #(
    parameter int c_NUM_REQ    = 4,
    parameter int c_ADDR_WIDTH = 10,
    parameter int c_DATA_WIDTH = 32,
    parameter int c_RD_LATENCY = 2,
    parameter int c_LEN_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    rom_read_arbiter_if.slave       bus,
    output logic [c_ADDR_WIDTH-1:0] rom_addr,
    output logic                    rom_clk_en,
    output logic                    rom_rd_oce,
    input  logic [c_DATA_WIDTH-1:0] rom_rd_data
);

    localparam int c_IDX_W = (c_NUM_REQ > 1) ? $clog2(c_NUM_REQ) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t                  state_q, state_d;
    logic [c_IDX_W-1:0]      ptr_q, ptr_d;
    logic [c_IDX_W-1:0]      owner_q, owner_d;
    logic [c_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [c_ADDR_WIDTH-1:0] hold_q, hold_d;
    logic [c_LEN_WIDTH-1:0]  remain_q, remain_d;

    logic [c_RD_LATENCY-1:0] pipeValid_q;
    logic [c_RD_LATENCY-1:0] pipeLast_q;
    logic [c_IDX_W-1:0]      pipeIdx_q [c_RD_LATENCY];

    logic                    grantFound;
    logic [c_IDX_W-1:0]      grantIdx;
    logic [c_IDX_W:0]        cand;
    logic [c_ADDR_WIDTH-1:0] grantAddr;
    logic [c_LEN_WIDTH-1:0]  grantLen;
    logic [c_NUM_REQ-1:0]    reqReady;
    logic [c_NUM_REQ-1:0]    rspValid;
    logic                    issue;
    logic                    isLast;

    // Upward search with wrap, starting at the priority pointer.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        cand       = '0;
        for (int k = 0; k < c_NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (c_IDX_W+1)'(k);
            if (cand >= (c_IDX_W+1)'(c_NUM_REQ)) begin
                cand = cand - (c_IDX_W+1)'(c_NUM_REQ);
            end
            if (!grantFound && bus.req_valid[cand[c_IDX_W-1:0]]) begin
                grantFound = 1'b1;
                grantIdx   = cand[c_IDX_W-1:0];
            end
        end
    end

    always_comb begin
        grantAddr = '0;
        grantLen  = '0;
        for (int i = 0; i < c_NUM_REQ; i++) begin
            if (grantIdx == c_IDX_W'(i)) begin
                grantAddr = bus.req_addr[i*c_ADDR_WIDTH +: c_ADDR_WIDTH];
                grantLen  = bus.req_len[i*c_LEN_WIDTH +: c_LEN_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        hold_d   = hold_q;
        remain_d = remain_q;
        reqReady = '0;
        issue    = 1'b0;
        isLast   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grantFound) begin
                    for (int i = 0; i < c_NUM_REQ; i++) begin
                        reqReady[i] = (grantIdx == c_IDX_W'(i));
                    end
                    owner_d  = grantIdx;
                    addr_d   = grantAddr;
                    remain_d = grantLen;
                    ptr_d    = (grantIdx == c_IDX_W'(c_NUM_REQ-1)) ? '0 : grantIdx + 1'b1;
                    state_d  = ST_BURST;
                end
            end
            ST_BURST: begin
                issue    = 1'b1;
                isLast   = (remain_q == '0);
                hold_d   = addr_q;
                addr_d   = addr_q + 1'b1;
                remain_d = remain_q - 1'b1;
                if (isLast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage 0 captures the issue cycle; the last stage lines up with ROM data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            addr_q      <= '0;
            hold_q      <= '0;
            remain_q    <= '0;
            pipeValid_q <= '0;
            pipeLast_q  <= '0;
            for (int i = 0; i < c_RD_LATENCY; i++) begin
                pipeIdx_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            owner_q        <= owner_d;
            addr_q         <= addr_d;
            hold_q         <= hold_d;
            remain_q       <= remain_d;
            pipeValid_q[0] <= issue;
            pipeLast_q[0]  <= isLast;
            pipeIdx_q[0]   <= owner_q;
            for (int i = 1; i < c_RD_LATENCY; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
                pipeLast_q[i]  <= pipeLast_q[i-1];
                pipeIdx_q[i]   <= pipeIdx_q[i-1];
            end
        end
    end

    always_comb begin
        rspValid = '0;
        for (int i = 0; i < c_NUM_REQ; i++) begin
            rspValid[i] = !rst && pipeValid_q[c_RD_LATENCY-1]
                          && (pipeIdx_q[c_RD_LATENCY-1] == c_IDX_W'(i));
        end
    end

    // Outputs are forced quiet while reset is held, independent of register contents.
    assign bus.req_ready = rst ? '0 : reqReady;
    assign bus.rsp_valid = rspValid;
    assign bus.rsp_last  = !rst && pipeValid_q[c_RD_LATENCY-1] && pipeLast_q[c_RD_LATENCY-1];
    assign bus.rsp_data  = rst ? '0 : rom_rd_data;
    assign rom_addr      = rst ? '0 : (issue ? addr_q : hold_q);
    assign rom_clk_en    = !rst && (issue || (|pipeValid_q));
    assign rom_rd_oce    = (c_RD_LATENCY == 2) ? rom_clk_en : 1'b0;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboarded bench driving identical requests into a latency-2 and a latency-1 arbiter,
// each backed by a small behavioural ROM that returns a word derived from its address.
module tb_rom_read_arbiter;

    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 4;

    typedef struct {
        int          cyc;
        int          idx;
        logic [DW-1:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0]    reqValid;
    logic [NR*AW-1:0] reqAddr;
    logic [NR*LW-1:0] reqLen;
    logic             autoDrop;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [NR-1:0] lastGrant;
    int            lastGrantCyc;
    logic [AW-1:0] lastAddr;
    logic [NR-1:0] lastRsp [2];
    logic          lastRspLast [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] romWord(input logic [AW-1:0] a);
        return {6'h2A, a, 6'h15, a};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, observed, expected);
        end
    endtask

    for (genvar u = 0; u < 2; u++) begin : g
        localparam int LAT = (u == 0) ? 2 : 1;

        rom_read_arbiter_if #(.c_NUM_REQ(NR), .c_ADDR_WIDTH(AW), .c_DATA_WIDTH(DW), .c_LEN_WIDTH(LW)) bus ();

        logic [AW-1:0] romAddr;
        logic          romClkEn;
        logic          romOce;
        logic [DW-1:0] romData;
        logic [DW-1:0] romReg1;
        logic [DW-1:0] romReg2;

        assign bus.req_valid = reqValid;
        assign bus.req_addr  = reqAddr;
        assign bus.req_len   = reqLen;

        rom_read_arbiter #(
            .c_NUM_REQ(NR), .c_ADDR_WIDTH(AW), .c_DATA_WIDTH(DW),
            .c_RD_LATENCY(LAT), .c_LEN_WIDTH(LW)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .bus        (bus),
            .rom_addr   (romAddr),
            .rom_clk_en (romClkEn),
            .rom_rd_oce (romOce),
            .rom_rd_data(romData)
        );

        // ROM: address register gated by clock enable, optional output register gated by oce.
        always @(posedge clk) begin
            if (romClkEn) romReg1 <= romWord(romAddr);
            if (romOce)   romReg2 <= romReg1;
        end
        assign romData = (LAT == 2) ? romReg2 : romReg1;

        exp_t q[$];
        int   pending = 0;
        int   mBusy = 0;
        int   mPtr = 0;
        int   mOwner = 0;
        logic [AW-1:0] mAddr = '0;

        // Reference model: round-robin grant, sequential issue, scoreboard of expected responses.
        always @(negedge clk) begin : model
            logic [NR-1:0] expReady;
            logic          expIssue;
            logic          expClk;
            int            gi;
            exp_t          e;
            expReady = '0;
            expIssue = 1'b0;
            if (rst) begin
                checkOutput($sformatf("L%0d rst req_ready", LAT), bus.req_ready, 0);
                checkOutput($sformatf("L%0d rst rsp_valid", LAT), bus.rsp_valid, 0);
                checkOutput($sformatf("L%0d rst rsp_last", LAT), bus.rsp_last, 0);
                checkOutput($sformatf("L%0d rst rsp_data", LAT), bus.rsp_data, 0);
                checkOutput($sformatf("L%0d rst rom_addr", LAT), romAddr, 0);
                checkOutput($sformatf("L%0d rst rom_clk_en", LAT), romClkEn, 0);
                checkOutput($sformatf("L%0d rst rom_rd_oce", LAT), romOce, 0);
                q.delete();
                mBusy = 0;
                mPtr  = 0;
            end else begin
                if (mBusy == 0) begin
                    gi = -1;
                    for (int k = 0; k < NR; k++) begin
                        if (gi < 0 && reqValid[(mPtr + k) % NR]) gi = (mPtr + k) % NR;
                    end
                    if (gi >= 0) begin
                        expReady[gi] = 1'b1;
                        mAddr  = reqAddr[gi*AW +: AW];
                        mBusy  = int'(reqLen[gi*LW +: LW]) + 1;
                        mOwner = gi;
                        mPtr   = (gi + 1) % NR;
                    end
                end else begin
                    e.cyc  = cyc + LAT;
                    e.idx  = mOwner;
                    e.data = romWord(mAddr);
                    e.last = (mBusy == 1);
                    q.push_back(e);
                    checkOutput($sformatf("L%0d rom_addr", LAT), romAddr, mAddr);
                    mAddr    = mAddr + 1'b1;
                    mBusy    = mBusy - 1;
                    expIssue = 1'b1;
                end
                checkOutput($sformatf("L%0d req_ready", LAT), bus.req_ready, expReady);
                expClk = expIssue || (q.size() > 0 && q[0].cyc <= cyc + LAT - 1);
                checkOutput($sformatf("L%0d rom_clk_en", LAT), romClkEn, expClk);
                checkOutput($sformatf("L%0d rom_rd_oce", LAT), romOce, (LAT == 2) ? expClk : 1'b0);
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    e = q.pop_front();
                    checkOutput($sformatf("L%0d rsp_valid", LAT), bus.rsp_valid, 64'(1) << e.idx);
                    checkOutput($sformatf("L%0d rsp_data", LAT), bus.rsp_data, e.data);
                    checkOutput($sformatf("L%0d rsp_last", LAT), bus.rsp_last, e.last);
                end else begin
                    checkOutput($sformatf("L%0d rsp_valid quiet", LAT), bus.rsp_valid, 0);
                    checkOutput($sformatf("L%0d rsp_last quiet", LAT), bus.rsp_last, 0);
                end
            end
            pending = q.size();
        end
    end

    // One clock: sample just after the falling edge, release granted requests after the rising edge.
    task automatic tick();
        @(negedge clk);
        #1;
        lastGrant      = g[0].bus.req_ready;
        lastGrantCyc   = cyc;
        lastAddr       = g[0].romAddr;
        lastRsp[0]     = g[0].bus.rsp_valid;
        lastRsp[1]     = g[1].bus.rsp_valid;
        lastRspLast[0] = g[0].bus.rsp_last;
        lastRspLast[1] = g[1].bus.rsp_last;
        @(posedge clk);
        #1;
        if (autoDrop) reqValid = reqValid & ~lastGrant;
    endtask

    task automatic applyStimulus(input int i, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        reqAddr[i*AW +: AW] = addr;
        reqLen[i*LW +: LW]  = len;
        reqValid[i]         = 1'b1;
    endtask

    task automatic waitGrant(input string tag, input logic [NR-1:0] expMask);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (lastGrant == '0 && n < 50);
        checkOutput(tag, lastGrant, expMask);
    endtask

    initial begin
        int firstC [2];
        int lastC [2];
        int words [2];
        int lasts [2];
        int prevCyc;
        int quiet;
        logic [AW-1:0] wrapAddr [4];

        rst      = 1'b1;
        reqValid = '0;
        reqAddr  = '0;
        reqLen   = '0;
        autoDrop = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single burst from requester 1.
        applyStimulus(1, 10'h010, 4'd3);
        waitGrant("single grant", 4'b0010);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k <= 4) checkOutput("single rom_addr", lastAddr, 10'h010 + 10'(k - 1));
            checkOutput("single rsp_valid", lastRsp[0], (k >= 3 && k <= 6) ? 4'b0010 : 4'b0000);
            checkOutput("single rsp_last", lastRspLast[0], k == 6);
        end
        repeat (4) tick();

        // All four requesters held valid with single-word bursts, starting from a fresh pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        autoDrop = 1'b0;
        for (int i = 0; i < NR; i++) applyStimulus(i, 10'h100 + 10'(i * 32), 4'd0);
        prevCyc = 0;
        for (int n = 0; n < 5; n++) begin
            waitGrant($sformatf("rr grant %0d", n), 4'(1 << (n % 4)));
            if (n > 0) checkOutput("rr spacing", lastGrantCyc - prevCyc, 2);
            prevCyc = lastGrantCyc;
        end
        reqValid = '0;
        autoDrop = 1'b1;
        repeat (6) tick();

        // Address wrap at the top of the ROM.
        wrapAddr[0] = 10'h3FE;
        wrapAddr[1] = 10'h3FF;
        wrapAddr[2] = 10'h000;
        wrapAddr[3] = 10'h001;
        applyStimulus(2, 10'h3FE, 4'd3);
        waitGrant("wrap grant", 4'b0100);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("wrap rom_addr %0d", k), lastAddr, wrapAddr[k]);
        end
        repeat (6) tick();

        // Reset in the middle of an 8-word burst.
        applyStimulus(1, 10'h040, 4'd7);
        waitGrant("midrst grant", 4'b0010);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        quiet = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            quiet += int'(lastRsp[0] != '0) + int'(lastRsp[1] != '0);
        end
        checkOutput("midrst rsp after reset", quiet, 0);
        applyStimulus(0, 10'h080, 4'd1);
        applyStimulus(2, 10'h0C0, 4'd1);
        waitGrant("midrst regrant", 4'b0001);
        repeat (10) tick();

        // Back-to-back bursts from requesters 3 and 2.
        applyStimulus(2, 10'h200, 4'd2);
        applyStimulus(3, 10'h300, 4'd3);
        for (int u = 0; u < 2; u++) begin
            firstC[u] = -1;
            lastC[u]  = -1;
            words[u]  = 0;
            lasts[u]  = 0;
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            for (int u = 0; u < 2; u++) begin
                if (lastRsp[u] != '0) begin
                    if (firstC[u] < 0) firstC[u] = k;
                    lastC[u] = k;
                    words[u]++;
                end
                if (lastRspLast[u]) lasts[u]++;
            end
        end
        for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("b2b words L%0d", 2 - u), words[u], 7);
            checkOutput($sformatf("b2b span L%0d", 2 - u), lastC[u] - firstC[u] + 1, 8);
            checkOutput($sformatf("b2b lasts L%0d", 2 - u), lasts[u], 2);
        end

        // Requester 0 withdraws while requester 2 waits behind a running burst.
        applyStimulus(3, 10'h050, 4'd5);
        waitGrant("withdraw first grant", 4'b1000);
        tick();
        applyStimulus(0, 10'h060, 4'd0);
        applyStimulus(2, 10'h070, 4'd1);
        repeat (2) tick();
        reqValid[0] = 1'b0;
        waitGrant("withdraw second grant", 4'b0100);
        repeat (10) tick();

        checkOutput("drain L2", g[0].pending, 0);
        checkOutput("drain L1", g[1].pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
